// File: rtl/opsequencer.sv
// rtl/opsequencer.sv - sequences load and per-operation reads of an operation register
// Latches operand/mask on start, walks the enabled opsels and packs each returned value.
module opsequencer #(
  parameter int WIDTH = 4
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic               i_w_start,
  input  logic [WIDTH-1:0]   i_w_operand,
  input  logic [3:0]         i_w_opmask,
  input  logic [WIDTH-1:0]   i_w_result,
  output logic [WIDTH-1:0]   o_w_data,
  output logic               o_w_we,
  output logic               o_w_oe,
  output logic [1:0]         o_w_opsel,
  output logic [4*WIDTH-1:0] o_w_results,
  output logic               o_w_busy,
  output logic               o_w_done
);

  typedef enum logic [2:0] {IDLE, LOAD, SEL, READ, DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         k, k_next;
  logic [WIDTH-1:0]   operand;
  logic [3:0]         mask;
  logic [4*WIDTH-1:0] results;
  logic [3:0]         pending;
  logic               has_next;
  logic [1:0]         next_idx;
  logic               we_q, oe_q, busy_q, done_q;
  logic [1:0]         opsel_q;

  // From LOAD scan the whole mask; from READ only bits above the current op.
  always_comb begin
    pending  = (state == READ) ? (mask & (4'b1110 << k)) : mask;
    has_next = 1'b0;
    next_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        has_next = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    case (state)
      IDLE: begin
        if (i_w_start) begin
          state_next = LOAD;
          k_next     = 2'd0;
        end
      end
      LOAD, READ: begin
        if (has_next) begin
          state_next = SEL;
          k_next     = next_idx;
        end else begin
          state_next = DONE;
        end
      end
      SEL:  state_next = READ;
      DONE: begin
        state_next = IDLE;
        k_next     = 2'd0;
      end
      default: begin
        state_next = IDLE;
        k_next     = 2'd0;
      end
    endcase
  end

  // Control outputs are flops fed from the next-state decode, so they never glitch.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state   <= IDLE;
      k       <= 2'd0;
      operand <= '0;
      mask    <= 4'd0;
      results <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      opsel_q <= 2'd0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (state == IDLE && i_w_start) begin
        operand <= i_w_operand;
        mask    <= i_w_opmask;
        results <= '0;
      end
      if (state == READ) begin
        results[32'(k)*WIDTH +: WIDTH] <= i_w_result;
      end
      we_q    <= (state_next == LOAD);
      oe_q    <= (state_next == READ);
      busy_q  <= (state_next == LOAD) || (state_next == SEL) || (state_next == READ);
      done_q  <= (state_next == DONE);
      opsel_q <= ((state_next == SEL) || (state_next == READ)) ? k_next : 2'd0;
    end
  end

  assign o_w_data    = operand;
  assign o_w_results = results;
  assign o_w_we      = we_q;
  assign o_w_oe      = oe_q;
  assign o_w_busy    = busy_q;
  assign o_w_done    = done_q;
  assign o_w_opsel   = opsel_q;

endmodule
